mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Owns the single byte-wide RAM/IO port and shares it between instruction fetch (IF) and the
//   load/store buffer (LSB). Serialises each accepted request into 1/2/4 byte beats, assembles
//   read bytes little-endian, and returns one done pulse per transaction. Sits between the core
//   front/back ends and the top-level mem_din/mem_dout/mem_a/mem_wr pins.
// PARAMETERS
//   IO_BASE   32'h0003_0000  addresses >= IO_BASE are I/O; writes there obey io_buffer_full
//   IF_BYTES  4              bytes fetched per IF request (1..4)
// PORTS
//   clk_in          in   1   clock, rising edge
//   rst_in          in   1   reset, synchronous, active-high
//   rdy_in          in   1   global enable; low = freeze
//   clear           in   1   control-hazard flush from ROB commit
//   io_buffer_full  in   1   UART buffer full; blocks I/O writes
//   if_req          in   1   IF request, held until if_done
//   if_addr         in   32  IF byte address
//   if_done         out  1   one-cycle pulse: if_data valid
//   if_data         out  32  fetched word, little-endian
//   ls_req          in   1   LSB request, held until ls_done
//   ls_wr           in   1   1 = store, 0 = load
//   ls_size         in   2   0:1B 1:2B 2:4B (3 treated as 1B)
//   ls_addr         in   32  LSB byte address
//   ls_wdata        in   32  store data, byte 0 written first
//   ls_done         out  1   one-cycle pulse: store finished / ls_rdata valid
//   ls_rdata        out  32  load bytes, zero-filled above size (LSB sign-extends)
//   busy            out  1   state != IDLE
//   mem_din         in   8   RAM read data, 1-cycle latency after mem_a
//   mem_dout        out  8   RAM write data
//   mem_a           out  32  RAM address
//   mem_wr          out  1   1 = write this cycle
// BEHAVIOUR
//   Reset: state IDLE, cnt=0, if_done=ls_done=0, if_data=ls_rdata=0, mem_a=0, mem_dout=0,
//     mem_wr=0, busy=0. Reset asserted mid-transaction aborts it; no done pulse.
//   States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
//   IDLE: ls_req wins over if_req (fixed priority, no preemption). Accept edge latches addr, size
//     (n bytes), wdata, owner; cnt<=0; state -> IF_RD / LS_RD / LS_WR.
//   Reads (n bytes): beat cycles k=0..n-1 drive mem_a=addr+k, mem_wr=0; byte k is captured into
//     bits [8k+7:8k] at the edge ending cycle k+1. One extra cycle after beat n-1 for the last
//     capture -> DONE. Accept edge to done cycle = n+1 edges (4B: done 5 cycles after accept).
//   Writes: beat k drives mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1; after beat n-1 -> DONE;
//     done n edges after accept. If addr+k >= IO_BASE and io_buffer_full=1: mem_wr=0, cnt holds.
//   DONE: exactly one cycle; matching done=1, data stable; no accept this cycle; -> IDLE. Requester
//     must drop req by end of DONE; a held req starts a new transaction from IDLE.
//   mem_a/mem_wr=0 in IDLE and DONE. Address adds are 32-bit wrap (0xFFFFFFFF+1 = 0).
//   clear: IF_RD or LS_RD -> IDLE next edge, no done; done outputs gated to 0 in a clear cycle
//     for IF and loads. LS_WR unaffected (stores are committed). clear in IDLE: no accept.
//   rdy_in=0: all registers hold; mem_wr forced 0; mem_a keeps its value so pending read data stays
//     valid; resumes exactly where stopped.
//   Exactly one owner per transaction; if_done and ls_done never both high.
// TESTING
//   RAM[0x100..0x103]=13 00 00 93, if_req@0x100 -> if_done 5 cycles after accept, if_data=0x93000013.
//   if_req & ls_req(load,2B,@0x200=EF BE) same cycle -> ls_done first, ls_rdata=0x0000BEEF; IF runs next.
//   Store 4B 0xDEADBEEF@0x10 -> mem_wr on 4 cycles, a=0x10..0x13, dout=EF,BE,AD,DE; ls_done on 5th.
//   Store 1B 0x41@0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 while full; then 1 write, done.
//   clear on 2nd beat of IF read -> IDLE, no if_done; pending ls_req accepted next cycle.
//   rdy_in low 4 cycles mid 4B load -> result identical to uninterrupted run, done delayed 4 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the single byte-wide RAM/IO port between instruction
//            fetch (IF) and the load/store buffer (LSB). Each accepted request
//            is split into 1/2/4 byte beats. Read bytes are assembled
//            little-endian. Each transaction returns exactly one done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in, rst_in        clock (rising edge), synchronous active-high reset
//   rdy_in                global enable; low freezes the arbiter
//   clear                 flush: aborts in-flight IF fetches and loads
//   io_buffer_full        stalls write beats that target the I/O region
//   if_req/if_addr        fetch request (held until if_done)
//   if_done/if_data       one-cycle completion pulse and fetched word
//   ls_req/ls_wr/ls_size  load/store request, direction and size code
//   ls_addr/ls_wdata      load/store address and store data
//   ls_done/ls_rdata      one-cycle completion pulse and zero-filled load data
//   busy                  high whenever a transaction is in progress
//   mem_din/mem_dout      RAM read data (1-cycle latency) and write data
//   mem_a/mem_wr          RAM byte address and write strobe
// ============================================================================
module mem_port_arbiter #(
    parameter logic [31:0] IO_BASE  = 32'h0003_0000,
    parameter int unsigned IF_BYTES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        busy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IF_RD = 3'd1,
        S_LS_RD = 3'd2,
        S_LS_WR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] C_IF_NBYTES = IF_BYTES[2:0];

    // Size code to byte count; the unused code 3 behaves as a single byte.
    function automatic logic [2:0] f_size_bytes(input logic [1:0] sz);
        case (sz)
            2'd1:    f_size_bytes = 3'd2;
            2'd2:    f_size_bytes = 3'd4;
            default: f_size_bytes = 3'd1;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        own_ls_q, own_ls_d;
    logic        store_q, store_d;

    // Holds the RAM byte that was in flight when rdy_in dropped. mem_a is
    // frozen during the stall, so the RAM output drifts to the next address.
    // The byte owed to the capture logic is kept here until the stall ends.
    logic [7:0]  skid_q;
    logic        skid_vld_q;

    logic [31:0] w_beat_addr;
    logic        w_beat_active;
    logic        w_is_rd;
    logic        w_io_block;
    logic [7:0]  w_din;
    logic [7:0]  w_wbyte;
    logic        w_done_ok;

    assign w_beat_addr   = addr_q + {29'd0, cnt_q};
    assign w_beat_active = (cnt_q < nbytes_q);
    assign w_is_rd       = (state_q == S_IF_RD) || (state_q == S_LS_RD);
    assign w_io_block    = (w_beat_addr >= IO_BASE) && io_buffer_full;
    assign w_din         = skid_vld_q ? skid_q : mem_din;

    always_comb begin
        w_wbyte = 8'h00;
        case (cnt_q[1:0])
            2'd0: w_wbyte = wdata_q[7:0];
            2'd1: w_wbyte = wdata_q[15:8];
            2'd2: w_wbyte = wdata_q[23:16];
            2'd3: w_wbyte = wdata_q[31:24];
            default: w_wbyte = 8'h00;
        endcase
    end

    // The trailing capture-only read cycle drives address 0. This avoids a
    // spurious read of an I/O location past the end of the transfer.
    assign mem_a    = ((w_is_rd && w_beat_active) || (state_q == S_LS_WR)) ? w_beat_addr : 32'd0;
    assign mem_wr   = (state_q == S_LS_WR) && rdy_in && !w_io_block;
    assign mem_dout = (state_q == S_LS_WR) ? w_wbyte : 8'h00;
    assign busy     = (state_q != S_IDLE);

    // Done is qualified by rdy_in, so a frozen DONE state yields one pulse.
    // Stores are already committed, so a flush cannot suppress their done.
    assign w_done_ok = (state_q == S_DONE) && rdy_in && !(clear && !store_q);
    assign if_done   = w_done_ok && !own_ls_q;
    assign ls_done   = w_done_ok && own_ls_q;
    assign if_data   = data_q;
    assign ls_rdata  = data_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nbytes_d = nbytes_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        own_ls_d = own_ls_q;
        store_d  = store_q;

        if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (!clear) begin
                        if (ls_req) begin
                            own_ls_d = 1'b1;
                            store_d  = ls_wr;
                            addr_d   = ls_addr;
                            wdata_d  = ls_wdata;
                            nbytes_d = f_size_bytes(ls_size);
                            cnt_d    = 3'd0;
                            data_d   = 32'd0;
                            state_d  = ls_wr ? S_LS_WR : S_LS_RD;
                        end else if (if_req) begin
                            own_ls_d = 1'b0;
                            store_d  = 1'b0;
                            addr_d   = if_addr;
                            nbytes_d = C_IF_NBYTES;
                            cnt_d    = 3'd0;
                            data_d   = 32'd0;
                            state_d  = S_IF_RD;
                        end
                    end
                end
                S_IF_RD, S_LS_RD: begin
                    if (clear) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        // The byte for the address driven last cycle arrives now.
                        case (cnt_q)
                            3'd1: data_d[7:0]   = w_din;
                            3'd2: data_d[15:8]  = w_din;
                            3'd3: data_d[23:16] = w_din;
                            3'd4: data_d[31:24] = w_din;
                            default: ;
                        endcase
                        if (cnt_q == nbytes_q) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                S_LS_WR: begin
                    if (!w_io_block) begin
                        if (cnt_q == (nbytes_q - 3'd1)) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            nbytes_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            data_q   <= 32'd0;
            own_ls_q <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nbytes_q <= nbytes_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            own_ls_q <= own_ls_d;
            store_q  <= store_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            skid_q     <= 8'h00;
            skid_vld_q <= 1'b0;
        end else if (!rdy_in) begin
            if (!skid_vld_q) begin
                skid_q     <= mem_din;
                skid_vld_q <= 1'b1;
            end
        end else begin
            skid_vld_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard bench for mem_port_arbiter with a byte RAM
//            model (1-cycle read latency, I/O region not backed by storage).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic        if_req, ls_req, ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_done, ls_done, busy, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;

    always #5 clk_in = ~clk_in;

    mem_port_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .busy(busy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr)
    );

    typedef struct {
        bit          ls;
        bit          chk;
        logic [31:0] data;
    } done_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    done_t exp_done_q[$];
    wr_t   exp_wr_q[$];
    done_t mon_e;
    wr_t   mon_w;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    lat;

    // RAM model: preloaded while in reset; I/O addresses are not stored.
    logic [7:0] ram [0:4095];
    initial begin
        forever begin
            @(posedge clk_in);
            if (rst_in) begin
                for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
                ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h00;
                ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h93;
                ram[12'h200] <= 8'hEF; ram[12'h201] <= 8'hBE;
                ram[12'h300] <= 8'h11; ram[12'h301] <= 8'h22;
                ram[12'h302] <= 8'h33; ram[12'h303] <= 8'h44;
                ram[12'hFFF] <= 8'h5A; ram[12'h000] <= 8'hA5;
            end else if (mem_wr && (mem_a < 32'h0003_0000)) begin
                ram[mem_a[11:0]] <= mem_dout;
            end
            mem_din <= ram[mem_a[11:0]];
        end
    end

    // Scoreboard monitor: compares every done pulse and every write beat.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (if_done || ls_done) begin
                    n_cmp++;
                    if (exp_done_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL done_unexpected: got if_done=%0d ls_done=%0d, expected none", if_done, ls_done);
                    end else begin
                        mon_e = exp_done_q.pop_front();
                        if ((if_done && ls_done) || (ls_done != mon_e.ls)) begin
                            n_bad++;
                            $display("FAIL done_owner: got if_done=%0d ls_done=%0d, expected ls=%0d", if_done, ls_done, mon_e.ls);
                        end else if (mon_e.chk && ((mon_e.ls ? ls_rdata : if_data) !== mon_e.data)) begin
                            n_bad++;
                            $display("FAIL done_data: got %h, expected %h", mon_e.ls ? ls_rdata : if_data, mon_e.data);
                        end
                    end
                end
                if (mem_wr) begin
                    n_cmp++;
                    if (exp_wr_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL wr_unexpected: got a=%h d=%h, expected no write", mem_a, mem_dout);
                    end else begin
                        mon_w = exp_wr_q.pop_front();
                        if (mem_a !== mon_w.a || mem_dout !== mon_w.d) begin
                            n_bad++;
                            $display("FAIL wr_beat: got a=%h d=%h, expected a=%h d=%h", mem_a, mem_dout, mon_w.a, mon_w.d);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_done(input bit ls, input bit chkd, input logic [31:0] d);
        done_t t;
        t.ls = ls; t.chk = chkd; t.data = d;
        exp_done_q.push_back(t);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
        wr_t t;
        t.a = a; t.d = d;
        exp_wr_q.push_back(t);
    endtask

    task automatic issue_ls(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        ls_req = 1'b1; ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = d;
    endtask

    // Called in the cycle the request is first presented (cycle 0). Cycle k
    // gets io_buffer_full/rdy_in/clear from the windows. Returns the number
    // of clock edges from the accept edge to the start of the done cycle.
    // Returns one cycle after done, with the side controls back to idle.
    task automatic run_txn(input bit ls, input int full_lo, input int full_hi,
                           input int rdy_lo, input int rdy_hi, input int clr_at,
                           output int lat_o);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(negedge clk_in);
            if (ls ? ls_done : if_done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk_in); #1;
                cyc++;
                io_buffer_full = (cyc >= full_lo && cyc <= full_hi);
                rdy_in         = !(cyc >= rdy_lo && cyc <= rdy_hi);
                clear          = (cyc == clr_at);
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL txn_timeout: got no done after %0d cycles, expected a done", cyc);
        end
        @(posedge clk_in); #1;
        io_buffer_full = 1'b0; rdy_in = 1'b1; clear = 1'b0;
        lat_o = cyc - 1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_if_done",  {31'd0, if_done}, 32'd0);
        chk("rst_ls_done",  {31'd0, ls_done}, 32'd0);
        chk("rst_if_data",  if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_mem_a",    mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // 4-byte fetch.
        push_done(1'b0, 1'b1, 32'h9300_0013);
        if_req = 1'b1; if_addr = 32'h100;
        run_txn(1'b0, 1, 0, 1, 0, -1, lat);
        if_req = 1'b0;
        chk("if_lat", lat, 5);

        // Simultaneous requests: the load wins, then the fetch runs.
        push_done(1'b1, 1'b1, 32'h0000_BEEF);
        push_done(1'b0, 1'b1, 32'h9300_0013);
        if_req = 1'b1; if_addr = 32'h100;
        issue_ls(1'b0, 2'd1, 32'h200, 32'd0);
        run_txn(1'b1, 1, 0, 1, 0, -1, lat);
        ls_req = 1'b0;
        chk("ld2_lat", lat, 3);
        run_txn(1'b0, 1, 0, 1, 0, -1, lat);
        if_req = 1'b0;
        chk("if_after_ld_lat", lat, 5);

        // 4-byte store, then read it back.
        push_wr(32'h10, 8'hEF); push_wr(32'h11, 8'hBE);
        push_wr(32'h12, 8'hAD); push_wr(32'h13, 8'hDE);
        push_done(1'b1, 1'b0, 32'd0);
        issue_ls(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);
        run_txn(1'b1, 1, 0, 1, 0, -1, lat);
        ls_req = 1'b0;
        chk("st4_lat", lat, 4);
        push_done(1'b1, 1'b1, 32'hDEAD_BEEF);
        issue_ls(1'b0, 2'd2, 32'h10, 32'd0);
        run_txn(1'b1, 1, 0, 1, 0, -1, lat);
        ls_req = 1'b0;

        // A flush during a store has no effect on it.
        push_wr(32'h20, 8'hFE); push_wr(32'h21, 8'hCA);
        push_done(1'b1, 1'b0, 32'd0);
        issue_ls(1'b1, 2'd1, 32'h20, 32'h0000_CAFE);
        run_txn(1'b1, 1, 0, 1, 0, 1, lat);
        ls_req = 1'b0;
        chk("st2_clear_lat", lat, 2);

        // I/O store blocked for 3 cycles by a full buffer.
        push_wr(32'h0003_0000, 8'h41);
        push_done(1'b1, 1'b0, 32'd0);
        issue_ls(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
        run_txn(1'b1, 1, 3, 1, 0, -1, lat);
        ls_req = 1'b0;
        chk("io_st_lat", lat, 4);

        // Flush on the second beat of a fetch; the pending load goes next.
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk_in); #1;
        issue_ls(1'b0, 2'd2, 32'h300, 32'd0);
        @(posedge clk_in); #1;
        clear = 1'b1;
        @(posedge clk_in); #1;
        clear = 1'b0;
        if_req = 1'b0;
        chk("clear_to_idle", {31'd0, busy}, 32'd0);
        push_done(1'b1, 1'b1, 32'h4433_2211);
        run_txn(1'b1, 1, 0, 1, 0, -1, lat);
        ls_req = 1'b0;
        chk("ld_after_clear_lat", lat, 5);

        // rdy_in low for 4 cycles in the middle of a 4-byte load.
        push_done(1'b1, 1'b1, 32'h4433_2211);
        issue_ls(1'b0, 2'd2, 32'h300, 32'd0);
        run_txn(1'b1, 1, 0, 3, 6, -1, lat);
        ls_req = 1'b0;
        chk("ld_stall_lat", lat, 9);

        // Address wrap at the top of the address space.
        push_done(1'b1, 1'b1, 32'h0000_A55A);
        issue_ls(1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0);
        run_txn(1'b1, 1, 0, 1, 0, -1, lat);
        ls_req = 1'b0;
        chk("ld_wrap_lat", lat, 3);

        // Size code 3 behaves as one byte.
        push_done(1'b1, 1'b1, 32'h0000_00BE);
        issue_ls(1'b0, 2'd3, 32'h201, 32'd0);
        run_txn(1'b1, 1, 0, 1, 0, -1, lat);
        ls_req = 1'b0;
        chk("ld_size3_lat", lat, 2);

        // Reset in the middle of a fetch aborts it without a done.
        if_req = 1'b1; if_addr = 32'h100;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        if_req = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_mem_a", mem_a, 32'd0);
        chk("abort_data",  if_data, 32'd0);
        repeat (8) @(posedge clk_in);
        #1;

        chk("done_queue_drained", exp_done_q.size(), 32'd0);
        chk("wr_queue_drained",   exp_wr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
